// File: rtl/vred_pkg.sv
// Shared types and helpers for the vector reduction sequencer.
package vred_pkg;

  localparam int DATA_W = 64;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [2:0] {
    RED_SUM  = 3'd0,
    RED_MINU = 3'd1,
    RED_MIN  = 3'd2,
    RED_MAXU = 3'd3,
    RED_MAX  = 3'd4
  } red_op_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC    = 3'd1,
    ST_FOLD   = 3'd2,
    ST_SCALAR = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Halvings needed to fold 64 bits down to a single SEW-wide element.
  function automatic logic [1:0] fold_steps(input logic [1:0] sew);
    return 2'd3 - sew;
  endfunction

  // Neutral element of op, replicated into every SEW lane of a 64-bit word.
  function automatic logic [DATA_W-1:0] identity(input logic [2:0] op, input logic [1:0] sew);
    logic [DATA_W-1:0] v;
    logic              top;
    int                nb;
    v  = '0;
    nb = 1 << sew;
    for (int j = 0; j < NBYTES; j++) begin
      top = ((j % nb) == (nb - 1));
      case (op)
        RED_MINU: v[j*8 +: 8] = 8'hFF;
        RED_MIN:  v[j*8 +: 8] = top ? 8'h7F : 8'hFF;
        RED_MAX:  v[j*8 +: 8] = top ? 8'h80 : 8'h00;
        default:  v[j*8 +: 8] = 8'h00;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/vred_lane_combine.sv
// Lane-wise f(a, b) at SEW built from 8-bit add/subtract slices whose carry
// chains are broken at lane boundaries; disabled lanes pass a through.
module vred_lane_combine
  import vred_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        sew,
  input  logic [2:0]        op,
  input  logic [NBYTES-1:0] lane_en,
  output logic [DATA_W-1:0] y
);

  logic [2:0]        w_lane_mask;
  logic [DATA_W-1:0] w_sum;
  logic [NBYTES-1:0] w_no_borrow;

  assign w_lane_mask = 3'((4'd1 << sew) - 4'd1);

  always_comb begin : slices
    logic       c_add;
    logic       c_sub;
    logic [8:0] t_add;
    logic [8:0] t_sub;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    w_sum       = '0;
    w_no_borrow = '0;
    c_add       = 1'b0;
    c_sub       = 1'b1;
    t_add       = '0;
    t_sub       = '0;
    for (int j = 0; j < NBYTES; j++) begin
      if ((j & int'(w_lane_mask)) == 0) begin
        c_add = 1'b0;
        c_sub = 1'b1;
      end
      t_add = {1'b0, a[j*8 +: 8]} + {1'b0, b[j*8 +: 8]} + {8'd0, c_add};
      t_sub = {1'b0, a[j*8 +: 8]} + {1'b0, ~b[j*8 +: 8]} + {8'd0, c_sub};
      w_sum[j*8 +: 8] = t_add[7:0];
      w_no_borrow[j]  = t_sub[8];
      c_add = t_add[8];
      c_sub = t_sub[8];
    end
  end

  always_comb begin : select
    int         top;
    int         lane;
    logic       lt;
    logic       is_signed;
    logic [7:0] res;
    y         = '0;
    top       = 0;
    lane      = 0;
    lt        = 1'b0;
    res       = '0;
    is_signed = (op == RED_MIN) || (op == RED_MAX);
    for (int j = 0; j < NBYTES; j++) begin
      top  = j | int'(w_lane_mask);
      lane = j >> sew;
      // Signed a<b: sign bits decide when they differ, else the unsigned borrow.
      if (is_signed && (a[top*8+7] != b[top*8+7])) lt = a[top*8+7];
      else                                          lt = ~w_no_borrow[top];
      case (op)
        RED_MINU, RED_MIN: res = lt ? a[j*8 +: 8] : b[j*8 +: 8];
        RED_MAXU, RED_MAX: res = lt ? b[j*8 +: 8] : a[j*8 +: 8];
        default:           res = w_sum[j*8 +: 8];
      endcase
      y[j*8 +: 8] = lane_en[lane] ? res : a[j*8 +: 8];
    end
  end

endmodule

// File: rtl/vred_seq.sv
// Reduction sequencer: accumulates vs2 beats lane-wise, tree-folds the
// accumulator to one element, combines with vs1[0] and holds the result.
module vred_seq
  import vred_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int SEW_WIDTH  = 2,
  parameter int OP_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    start_ready,
  input  logic [SEW_WIDTH-1:0]    sew,
  input  logic [OP_WIDTH-1:0]     op,
  input  logic [DATA_WIDTH-1:0]   scalar_init,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_be,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    busy
);

  state_e                  r_state, w_next;
  logic [SEW_WIDTH-1:0]    r_sew;
  logic [OP_WIDTH-1:0]     r_op;
  logic [DATA_WIDTH-1:0]   r_scalar, r_acc, r_out_data;
  logic [1:0]              r_step;
  logic                    r_out_valid, r_in_ready, r_busy, r_start_ready;

  logic [DATA_WIDTH-1:0]   w_a, w_b, w_y, w_lo_mask, w_sew_mask;
  logic [DATA_WIDTH/8-1:0] w_lane_en, w_be_lane;
  logic [6:0]              w_half, w_sew_bits;

  assign w_half     = 7'd32 >> r_step;
  assign w_lo_mask  = (64'd1 << w_half) - 64'd1;
  assign w_sew_bits = 7'd8 << r_sew;
  assign w_sew_mask = (r_sew == SEW_64) ? '1 : (64'd1 << w_sew_bits) - 64'd1;

  // A lane counts as active only if all of its bytes are enabled.
  always_comb begin
    w_be_lane = '1;
    for (int i = 0; i < DATA_WIDTH / 8; i++)
      for (int j = 0; j < DATA_WIDTH / 8; j++)
        if ((j >> r_sew) == i) w_be_lane[i] = w_be_lane[i] & in_be[j];
  end

  always_comb begin
    w_a       = r_acc;
    w_b       = in_data;
    w_lane_en = w_be_lane;
    case (r_state)
      ST_FOLD: begin
        w_a       = r_acc & w_lo_mask;
        w_b       = r_acc >> w_half;
        w_lane_en = '1;
      end
      ST_SCALAR: begin
        w_b       = r_scalar;
        w_lane_en = '1;
      end
      default: ;
    endcase
  end

  vred_lane_combine u_combine (
    .a       (w_a),
    .b       (w_b),
    .sew     (r_sew),
    .op      (r_op),
    .lane_en (w_lane_en),
    .y       (w_y)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_ACC;
      ST_ACC:    if (in_valid && in_last)
                   w_next = (fold_steps(r_sew) == 2'd0) ? ST_SCALAR : ST_FOLD;
      ST_FOLD:   if (r_step == fold_steps(r_sew) - 2'd1) w_next = ST_SCALAR;
      ST_SCALAR: w_next = ST_DONE;
      ST_DONE:   if (out_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sew         <= '0;
      r_op          <= '0;
      r_scalar      <= '0;
      r_acc         <= '0;
      r_step        <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_in_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_start_ready <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments, so every flop here samples pre-edge values.
      case (r_state)
        ST_IDLE: if (start) begin
          r_sew    <= sew;
          r_op     <= op;
          r_scalar <= scalar_init;
          r_acc    <= identity(op, sew);
          r_step   <= '0;
        end
        ST_ACC:    if (in_valid) r_acc <= w_y;
        ST_FOLD: begin
          r_acc  <= w_y & w_lo_mask;
          r_step <= r_step + 2'd1;
        end
        ST_SCALAR: r_out_data <= w_y & w_sew_mask;
        default: ;
      endcase
      r_out_valid   <= (w_next == ST_DONE);
      r_in_ready    <= (w_next == ST_ACC);
      r_busy        <= (w_next != ST_IDLE);
      r_start_ready <= (w_next == ST_IDLE);
    end
  end

  assign start_ready = r_start_ready;
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign busy        = r_busy;

endmodule

// File: tb/tb_vred_seq.sv
// Directed bench for vred_seq: hand-computed reductions, latency, masking,
// backpressure, mid-run reset and protocol corner cases.
module tb_vred_seq;
  import vred_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start_ready;
  logic [1:0]  sew = '0;
  logic [2:0]  op = '0;
  logic [63:0] scalar_init = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [7:0]  in_be = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vred_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_ready (start_ready),
    .sew         (sew),
    .op          (op),
    .scalar_init (scalar_init),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_be       (in_be),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  // Stimulus helpers (no comparisons inside). All are entered 1 time unit after a rising edge.
  task automatic do_start(input logic [1:0] s, input logic [2:0] o, input logic [63:0] sc);
    start = 1'b1; sew = s; op = o; scalar_init = sc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] be, input logic last);
    int cnt;
    cnt = 0;
    in_valid = 1'b1; in_data = d; in_be = be; in_last = last;
    while (!in_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
    if (in_ready) begin @(posedge clk); #1; end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // lat counts cycles after the last handshake: cycle T+1 is lat=1.
  task automatic wait_out(output int lat, output logic [63:0] d);
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    d = out_data;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (start_ready !== 1'b1) $display("FAIL reset_start_ready got %b want 1", start_ready); else n_pass++;
    n_total++; if (out_data !== 64'd0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sum8();
    int lat; logic [63:0] d;
    do_start(SEW_8, RED_SUM, 64'h05);
    n_total++; if (in_ready !== 1'b1) $display("FAIL sum8_in_ready_after_start got %b want 1", in_ready); else n_pass++;
    send_beat(64'h0807060504030201, 8'hFF, 1'b1);
    wait_out(lat, d);
    n_total++; if (d !== 64'h29) $display("FAIL sum8_data got %h want %h", d, 64'h29); else n_pass++;
    n_total++; if (lat !== 5) $display("FAIL sum8_latency got %0d want 5", lat); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL sum8_busy_in_done got %b want 1", busy); else n_pass++;
    accept();
    n_total++; if (start_ready !== 1'b1) $display("FAIL sum8_start_ready_after_accept got %b want 1", start_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL sum8_out_valid_after_accept got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_max16();
    int lat; logic [63:0] d;
    do_start(SEW_16, RED_MAX, 64'h0);
    send_beat(64'h8000_7FFF_0001_FFFF, 8'hFF, 1'b0);
    send_beat(64'h0002_0003_FFFE_0004, 8'hFF, 1'b1);
    wait_out(lat, d);
    n_total++; if (d !== 64'h7FFF) $display("FAIL max16_data got %h want %h", d, 64'h7FFF); else n_pass++;
    n_total++; if (lat !== 4) $display("FAIL max16_latency got %0d want 4", lat); else n_pass++;
    accept();
    do_start(SEW_16, RED_MAXU, 64'h0);
    send_beat(64'h8000_7FFF_0001_FFFF, 8'hFF, 1'b0);
    send_beat(64'h0002_0003_FFFE_0004, 8'hFF, 1'b1);
    wait_out(lat, d);
    n_total++; if (d !== 64'hFFFF) $display("FAIL maxu16_data got %h want %h", d, 64'hFFFF); else n_pass++;
    accept();
  endtask

  task automatic test_sum_wide();
    int lat; logic [63:0] d;
    do_start(SEW_32, RED_SUM, 64'h1);
    send_beat(64'hFFFFFFFF_00000002, 8'hFF, 1'b1);
    wait_out(lat, d);
    n_total++; if (d !== 64'h2) $display("FAIL sum32_wrap_data got %h want %h", d, 64'h2); else n_pass++;
    n_total++; if (lat !== 3) $display("FAIL sum32_latency got %0d want 3", lat); else n_pass++;
    accept();
    do_start(SEW_64, RED_SUM, 64'h0);
    send_beat(64'hFFFFFFFF_00000002, 8'hFF, 1'b1);
    wait_out(lat, d);
    n_total++; if (d !== 64'hFFFFFFFF_00000002) $display("FAIL sum64_data got %h want %h", d, 64'hFFFFFFFF_00000002); else n_pass++;
    n_total++; if (lat !== 2) $display("FAIL sum64_latency got %0d want 2", lat); else n_pass++;
    accept();
  endtask

  task automatic test_mask();
    int lat; logic [63:0] d;
    do_start(SEW_8, RED_MIN, 64'h10);
    send_beat(64'h00000000_7F7F7F01, 8'h0F, 1'b1);
    wait_out(lat, d);
    n_total++; if (d !== 64'h01) $display("FAIL min8_partial_mask got %h want %h", d, 64'h01); else n_pass++;
    accept();
    do_start(SEW_8, RED_MIN, 64'h10);
    send_beat(64'h00000000_7F7F7F01, 8'h00, 1'b1);
    wait_out(lat, d);
    n_total++; if (d !== 64'h10) $display("FAIL min8_all_masked got %h want %h", d, 64'h10); else n_pass++;
    accept();
  endtask

  task automatic test_backpressure();
    int lat; int data_moves; int sr_high; int ov_low; logic [63:0] d;
    data_moves = 0; sr_high = 0; ov_low = 0;
    do_start(SEW_8, RED_SUM, 64'h05);
    send_beat(64'h0807060504030201, 8'hFF, 1'b1);
    wait_out(lat, d);
    repeat (5) begin
      @(posedge clk); #1;
      if (out_data !== 64'h29) data_moves++;
      if (start_ready !== 1'b0) sr_high++;
      if (out_valid !== 1'b1) ov_low++;
    end
    n_total++; if (data_moves !== 0) $display("FAIL bp_data_stable got %0d changes want 0", data_moves); else n_pass++;
    n_total++; if (sr_high !== 0) $display("FAIL bp_start_ready_low got %0d high cycles want 0", sr_high); else n_pass++;
    n_total++; if (ov_low !== 0) $display("FAIL bp_out_valid_held got %0d low cycles want 0", ov_low); else n_pass++;
    accept();
  endtask

  task automatic test_reset_mid();
    int lat; int ov_seen; logic [63:0] d;
    ov_seen = 0;
    do_start(SEW_8, RED_SUM, 64'h05);
    send_beat(64'h0101010101010101, 8'hFF, 1'b0);
    rst = 1'b0;
    #2;
    n_total++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready got %b want 0", in_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
    n_total++; if (start_ready !== 1'b1) $display("FAIL midrst_start_ready got %b want 1", start_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    n_total++; if (ov_seen !== 0) $display("FAIL midrst_no_out_valid got %0d pulses want 0", ov_seen); else n_pass++;
    do_start(SEW_8, RED_SUM, 64'h05);
    send_beat(64'h0807060504030201, 8'hFF, 1'b1);
    wait_out(lat, d);
    n_total++; if (d !== 64'h29) $display("FAIL midrst_restart_data got %h want %h", d, 64'h29); else n_pass++;
    accept();
  endtask

  task automatic test_protocol();
    int lat; int bad; logic [63:0] d;
    bad = 0;
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_DEAD_BEEF; in_be = 8'hFF; in_last = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_total++; if (bad !== 0) $display("FAIL idle_in_valid_ignored got %0d bad cycles want 0", bad); else n_pass++;

    do_start(SEW_8, RED_SUM, 64'h05);
    start = 1'b1; sew = SEW_64; op = RED_MAX; scalar_init = 64'h99;
    @(posedge clk); #1;
    start = 1'b0;
    n_total++; if (in_ready !== 1'b1) $display("FAIL start_in_acc_in_ready got %b want 1", in_ready); else n_pass++;
    send_beat(64'h0807060504030201, 8'hFF, 1'b1);
    wait_out(lat, d);
    n_total++; if (d !== 64'h29) $display("FAIL start_in_acc_ignored got %h want %h", d, 64'h29); else n_pass++;
    bad = 0;
    in_valid = 1'b1; in_data = 64'hFFFF_FFFF_FFFF_FFFF; in_last = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (out_data !== 64'h29 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_total++; if (bad !== 0) $display("FAIL done_in_valid_ignored got %0d bad cycles want 0", bad); else n_pass++;
    accept();

    do_start(SEW_16, RED_MAX, 64'h0);
    send_beat(64'h8000_7FFF_0001_FFFF, 8'hFF, 1'b0);
    @(posedge clk); #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL gap_in_ready_held got %b want 1", in_ready); else n_pass++;
    send_beat(64'h0002_0003_FFFE_0004, 8'hFF, 1'b1);
    wait_out(lat, d);
    n_total++; if (d !== 64'h7FFF) $display("FAIL gapped_max16_data got %h want %h", d, 64'h7FFF); else n_pass++;
    n_total++; if (lat !== 4) $display("FAIL gapped_max16_latency got %0d want 4", lat); else n_pass++;
    accept();
  endtask

  initial begin
    test_reset();
    test_sum8();
    test_max16();
    test_sum_wide();
    test_mask();
    test_backpressure();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vred_seq.md
# vred_seq

Reduction sequencer for the vector ALU's `vredsum`/`vredmin`/`vredmax` family. It sits on the issue side of the reduction datapath and consumes a stream of 64-bit vs2 beats, accumulating them lane-wise into a running vector accumulator. After the last beat it tree-folds the accumulator down to one element, combines that element with the vs1[0] scalar, and presents the scalar result for writeback to vd[0].

## Interface

**Parameters**
- `DATA_WIDTH`, 64: beat and accumulator width. Fixed at 64.
- `SEW_WIDTH`, 2: width of the `sew` encoding.
- `OP_WIDTH`, 3: width of the `op` encoding.

**Ports**
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a reduction. Accepted only while `start_ready`=1.
- `start_ready` out 1: high in IDLE only.
- `sew` in 2: element width. 0=8, 1=16, 2=32, 3=64 bits. Latched on start.
- `op` in 3: SUM, MINU, MIN, MAXU, MAX. Latched on start.
- `scalar_init` in 64: vs1[0] in the low SEW bits. Latched on start.
- `in_valid` in 1: vs2 beat valid.
- `in_ready` out 1: high in ACC.
- `in_data` in 64: packed elements. Lane i occupies bits [i*SEW +: SEW].
- `in_be` in 8: byte enables. A lane is active iff all of its bytes are enabled.
- `in_last` in 1: final beat of the vector.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result accepted.
- `out_data` out 64: result in the low SEW bits. Upper bits are zero.
- `busy` out 1: state ≠ IDLE.

## Operation

**States:** IDLE → ACC → FOLD → SCALAR → DONE → IDLE.

**IDLE**
- On `start`, latch `sew`, `op` and `scalar_init`.
- Load `acc` with the identity for the op in every lane:
  - SUM and MAXU: 0.
  - MINU: all-ones.
  - MIN: most-positive signed value.
  - MAX: most-negative signed value.
- Go to ACC.

**ACC**
- On each `in_valid && in_ready` handshake, update every active lane: `acc[i] <= f(acc[i], in_data[i])`.
- Inactive lanes keep `acc[i]`.
- The handshake that carries `in_last` moves the block to FOLD.
- A vector with every lane masked is legal. The result is then `f(identity, scalar)`, which equals `scalar`.

**FOLD**
- Number of steps = 3, 2, 1 or 0 for SEW 8, 16, 32 or 64.
- At step k the live width is W = 64>>k. Each step does `acc[W/2-1:0] <= f(acc[W-1:W/2], acc[W/2-1:0])` lane-wise at SEW. All bits above W/2 are cleared.
- With SEW=64 there are zero steps, so FOLD is skipped and the block goes straight to SCALAR.

**SCALAR**
- `out_data <= zero-extend(f(acc[SEW-1:0], scalar_init[SEW-1:0]))`.
- Go to DONE.

**DONE**
- `out_valid`=1.
- `out_data` holds stable until `out_valid && out_ready`, then the block returns to IDLE.

**Arithmetic**
- SUM wraps modulo 2^SEW. There is no saturation and no carry across lanes.
- MIN and MAX compare as two's-complement at SEW. MINU and MAXU compare unsigned.
- Op codes 5–7 are reserved and behave as SUM.

**Boundary conditions**
- `start` outside IDLE is ignored. There is no queuing.
- `in_valid` outside ACC is not accepted, because `in_ready`=0.
- Reset asserted at any point returns the block to IDLE immediately. A partial reduction is discarded and no `out_valid` pulse is produced.

## Timing

**Reset values**
- `out_valid`=0, `in_ready`=0, `busy`=0, `start_ready`=1.
- `out_data`=0, `acc`=0, state=IDLE.

**Handshake timing**
- The cycle after `start` is accepted, `in_ready`=1.
- Throughput in ACC is one beat per cycle. `in_ready` stays high continuously until the last handshake.
- If the `in_last` handshake occurs in cycle T, `out_valid` rises in cycle T+steps+2. For SEW 8/16/32/64 that is T+5/T+4/T+3/T+2.
- `out_valid` holds until accepted. With `out_ready` held at 1, `start_ready` returns one cycle after `out_valid` rises.

**Register boundaries**
- All outputs are registered.
- The lane combine is combinational between `acc` and `acc`.

## Structure

**Shared package `vred_pkg`**
- Op enum: RED_SUM, RED_MINU, RED_MIN, RED_MAXU, RED_MAX.
- SEW encodings.
- State enum.
- `fold_steps(sew)` function.
- `identity(op, sew)` function, returning 64-bit replicated lanes.

**Sub-module `vred_lane_combine`**
- Combinational. Inputs: `a[63:0]`, `b[63:0]`, `sew`, `op`, `lane_en[7:0]`. Output: `y[63:0]`.
- Builds 8-bit adder and compare slices with carry-chain breaks selected by SEW.
- Instantiated once and muxed across ACC, FOLD and SCALAR.

## Test plan

- **SUM, SEW=8:** scalar=0x05, one beat 0x0807060504030201 with all bytes enabled and last → out_data=0x29, `out_valid` at T+5.
- **MAX, SEW=16:** two beats 0x8000_7FFF_0001_FFFF and 0x0002_0003_FFFE_0004, scalar=0x0000 → 0x7FFF. **MAXU** on the same input → 0xFFFF.
- **SUM, SEW=32 wrap:** beat 0xFFFFFFFF_00000002, scalar=1 → 0x00000002. **SEW=64** with the same beat and scalar=0 → 0xFFFFFFFF00000002 at T+2.
- **Masking, MIN, SEW=8:** beat 0x00000000_7F7F7F01 with `in_be`=0x0F, scalar=0x10 → 0x01. Same op with `in_be`=0x00 → 0x10.
- **Backpressure and reset:** hold `out_ready`=0 for 5 cycles → `out_data` stable and `start_ready`=0. Assert `rst` mid-ACC → outputs at reset values next cycle, no `out_valid`, and a new start then succeeds.
- **Protocol:** `start` during ACC ignored. `in_valid` with `in_ready`=0 never consumed. Gapped `in_valid` (1,0,1 with last) gives the same result as back-to-back beats.
